// File: rtl/parity_pkg.sv
// Shared types for the serial parity link: receiver FSM states and parity sense.
package parity_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// Bit-serial running-XOR parity engine; shared by the transmit and receive sides.
module parity_acc (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   input  logic bit_i,
   output logic acc_o
);

   logic acc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      acc_q <= 1'b0;
      else if (clr_i) acc_q <= 1'b0;
      else if (en_i)  acc_q <= acc_q ^ bit_i;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver: start, WIDTH data bits LSB-first, parity, stop.
// Completed words are presented on a valid/ready output register with error flags.
module parity_rx
   import parity_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ODD   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun
);

   localparam int   CW    = $clog2(WIDTH);
   localparam logic SENSE = (ODD != 0) ? PAR_ODD : PAR_EVEN;

   state_e           state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             perr_q, perr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             pe_q, pe_d;
   logic             fe_q, fe_d;
   logic             ovr_q, ovr_d;

   logic acc, acc_clr, acc_en, complete, accept, free;

   parity_acc u_acc (
      .clk   (clk),
      .reset (reset),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .bit_i (in),
      .acc_o (acc)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      perr_d    = perr_q;
      acc_clr   = 1'b0;
      acc_en    = 1'b0;
      complete  = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            IDLE: if (!in) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               acc_clr   = 1'b1;
            end
            DATA: begin
               // Right shift: the first received bit ends up at bit 0.
               shift_d   = {in, shift_q[WIDTH-1:1]};
               acc_en    = 1'b1;
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (bit_cnt_q == CW'(WIDTH-1)) state_d = PARITY;
            end
            PARITY: begin
               perr_d  = acc ^ in ^ SENSE;
               state_d = STOP;
            end
            STOP: begin
               complete = 1'b1;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign accept = valid_q & out_ready;
   assign free   = ~valid_q | accept;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      ovr_d   = ovr_q;
      if (accept) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      // A completion on the accept edge reloads the register instead of overrunning.
      if (complete) begin
         if (free) begin
            data_d  = shift_q;
            pe_d    = perr_q;
            fe_d    = ~in;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         perr_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         perr_q    <= perr_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
         ovr_q     <= ovr_d;
      end
   end

   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign parity_err = pe_q;
   assign frame_err  = fe_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: even-parity instance plus an odd-parity instance on the same line.
module tb_parity_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       in;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_valid, parity_err, frame_err, overrun;
   logic [7:0] o_data;
   logic       o_valid, o_perr, o_ferr, o_ovr;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   parity_rx #(.WIDTH(8), .ODD(0)) dut (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
   );

   parity_rx #(.WIDTH(8), .ODD(1)) dut_odd (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .out_data(o_data), .out_valid(o_valid), .out_ready(1'b1),
      .parity_err(o_perr), .frame_err(o_ferr), .overrun(o_ovr)
   );

   // All tasks start and end 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_bit(input logic b, input int gap);
      in_valid = 1'b0;
      repeat (gap) tick();
      in = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in = 1'b1;
   endtask

   task automatic send_head(input logic [7:0] d, input logic p, input int maxgap);
      send_bit(1'b0, $urandom_range(maxgap));
      for (int i = 0; i < 8; i++) send_bit(d[i], $urandom_range(maxgap));
      send_bit(p, $urandom_range(maxgap));
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int maxgap);
      send_head(d, p, maxgap);
      send_bit(s, $urandom_range(maxgap));
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s got %0h exp %0h", name, got, exp);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1; in = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      total++; if ({out_data, out_valid, parity_err, frame_err, overrun} !== 12'h000)
         $display("FAIL reset_outputs got %h exp 000", {out_data, out_valid, parity_err, frame_err, overrun});
      else passed++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      total++; if (out_valid !== 1'b1) $display("FAIL a5_valid got %b exp 1", out_valid); else passed++;
      total++; if (out_data !== 8'hA5) $display("FAIL a5_data got %h exp a5", out_data); else passed++;
      total++; if ({parity_err, frame_err} !== 2'b00)
         $display("FAIL a5_flags got %b exp 00", {parity_err, frame_err}); else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL a5_valid_drop got %b exp 0", out_valid); else passed++;
   endtask

   task automatic test_parity();
      send_frame(8'h07, 1'b0, 1'b1, 0);
      total++; if (out_data !== 8'h07) $display("FAIL p07_data got %h exp 07", out_data); else passed++;
      total++; if (parity_err !== 1'b1) $display("FAIL p07_even_perr got %b exp 1", parity_err); else passed++;
      total++; if ({o_valid, o_data, o_perr, o_ferr, o_ovr} !== {1'b1, 8'h07, 3'b000})
         $display("FAIL p07_odd got %h exp %h", {o_valid, o_data, o_perr, o_ferr, o_ovr}, {1'b1, 8'h07, 3'b000});
      else passed++;
      tick();
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0, 1'b0, 0);
      total++; if (out_data !== 8'h3C) $display("FAIL fe_data got %h exp 3c", out_data); else passed++;
      total++; if ({parity_err, frame_err} !== 2'b01)
         $display("FAIL fe_flags got %b exp 01", {parity_err, frame_err}); else passed++;
      tick();
      send_frame(8'h55, 1'b0, 1'b1, 0);
      total++; if ({out_valid, out_data, parity_err, frame_err} !== {1'b1, 8'h55, 2'b00})
         $display("FAIL fe_next got %h exp %h", {out_valid, out_data, parity_err, frame_err}, {1'b1, 8'h55, 2'b00});
      else passed++;
      tick();
   endtask

   task automatic test_overrun();
      out_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 0);
      total++; if ({out_valid, out_data, overrun} !== {1'b1, 8'h11, 1'b0})
         $display("FAIL ovr_first got %h exp %h", {out_valid, out_data, overrun}, {1'b1, 8'h11, 1'b0});
      else passed++;
      send_frame(8'h22, 1'b0, 1'b1, 0);
      total++; if (out_data !== 8'h11) $display("FAIL ovr_hold got %h exp 11", out_data); else passed++;
      total++; if ({out_valid, overrun} !== 2'b11)
         $display("FAIL ovr_flag got %b exp 11", {out_valid, overrun}); else passed++;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if ({out_valid, overrun} !== 2'b00)
         $display("FAIL ovr_accept got %b exp 00", {out_valid, overrun}); else passed++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 0);
      tick();
      total++; if ({out_valid, out_data} !== {1'b1, 8'h11})
         $display("FAIL b2b_held got %h exp %h", {out_valid, out_data}, {1'b1, 8'h11}); else passed++;
      send_head(8'h22, 1'b0, 0);
      out_ready = 1'b1;
      send_bit(1'b1, 0);
      out_ready = 1'b0;
      total++; if ({out_valid, out_data, overrun} !== {1'b1, 8'h22, 1'b0})
         $display("FAIL b2b_swap got %h exp %h", {out_valid, out_data, overrun}, {1'b1, 8'h22, 1'b0});
      else passed++;
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_gaps();
      send_frame(8'h81, 1'b0, 1'b1, 5);
      total++; if ({out_valid, out_data, parity_err, frame_err} !== {1'b1, 8'h81, 2'b00})
         $display("FAIL gap_81 got %h exp %h", {out_valid, out_data, parity_err, frame_err}, {1'b1, 8'h81, 2'b00});
      else passed++;
      tick();
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      send_frame(8'h07, 1'b0, 1'b1, 0);
      send_frame(8'h01, 1'b1, 1'b1, 0);
      total++; if ({out_valid, out_data, parity_err, overrun} !== {1'b1, 8'h07, 2'b11})
         $display("FAIL mr_pre got %h exp %h", {out_valid, out_data, parity_err, overrun}, {1'b1, 8'h07, 2'b11});
      else passed++;
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      #2 reset = 1'b1;
      #1;
      total++; if ({out_data, out_valid, parity_err, frame_err, overrun} !== 12'h000)
         $display("FAIL mr_async got %h exp 000", {out_data, out_valid, parity_err, frame_err, overrun});
      else passed++;
      #1 reset = 1'b0;
      out_ready = 1'b1;
      tick();
      send_frame(8'h5A, 1'b0, 1'b1, 0);
      total++; if ({out_valid, out_data, parity_err, frame_err, overrun} !== {1'b1, 8'h5A, 3'b000})
         $display("FAIL mr_next got %h exp %h", {out_valid, out_data, parity_err, frame_err, overrun}, {1'b1, 8'h5A, 3'b000});
      else passed++;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_gaps();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule

// File: doc/parity_rx.md
# parity_rx

Serial frame receiver with parity check. Samples a serial line one bit per `in_valid` strobe, strips the start bit, shifts in `WIDTH` data bits LSB-first, and accumulates their running XOR. It then compares the accumulated parity against the received parity bit and checks the stop bit. It is the receiving end of the team's serial parity link and presents each completed word, with error flags, on a valid/ready output register.

## Interface
- `WIDTH`, 8: data bits per frame (≥2).
- `ODD`, 0: parity sense; 0 = even (data ones + parity bit is even), 1 = odd.

- `clk` in 1: single clock, all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in` in 1: serial line, idle high.
- `in_valid` in 1: `in` is sampled only on edges where `in_valid`=1.
- `out_data` out WIDTH: received word; reset 0.
- `out_valid` out 1: word held in `out_data`; reset 0.
- `out_ready` in 1: consumer accepts the word on edges where `out_valid`&&`out_ready`.
- `parity_err` out 1: parity mismatch for the word in `out_data`; reset 0.
- `frame_err` out 1: stop bit was 0 for the word in `out_data`; reset 0.
- `overrun` out 1: sticky, a completed frame was dropped; reset 0.

## Operation
- Frame: start (0), `WIDTH` data bits LSB-first, parity bit, stop (1). Gaps of any length (`in_valid`=0) are allowed between bits.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions happen only on `in_valid` edges.
  - IDLE: sample 1 stays in IDLE; sample 0 goes to DATA, clears `bit_cnt` and the accumulator.
  - DATA: shift the sample into the shift register at the MSB (right shift, so after `WIDTH` bits bit0 = first received); XOR it into the accumulator; increment `bit_cnt`. After the `WIDTH`-th bit (`bit_cnt`==WIDTH-1), go to PARITY.
  - PARITY: `perr` = acc ^ sample ^ `ODD`, where 1 means error. Go to STOP.
  - STOP: go to IDLE and complete the frame.
    - `ferr` = ~sample.
    - If the output register is free, load it: `out_data` = shift register, `parity_err` = perr, `frame_err` = ferr, `out_valid` = 1.
- Output register is free on an edge when `out_valid`=0, or when `out_valid`&&`out_ready` on that same edge. Simultaneous accept and completion loads the new word with no overrun.
- Completion while not free: drop the frame, keep the held word unchanged, set `overrun`=1.
- Accept with no completion on the same edge: `out_valid`=0. `out_data` and the error flags may hold stale values.
- `overrun` clears only on an accept edge (`out_valid`&&`out_ready`) or on reset.
- A frame with `frame_err` is still delivered; there is no resynchronisation beyond returning to IDLE.
- Reset mid-frame: FSM goes to IDLE, the partial frame is discarded, and all outputs go to their reset values.

## Timing
- Latency: `out_valid` rises on the edge that samples the stop bit, so it is visible the cycle after the stop bit is presented.
- All outputs are registered; no combinational path from `in`/`out_ready` to any output.
- Throughput: one bit per cycle with `in_valid` held high. A frame takes `WIDTH`+3 valid cycles.
- `out_valid` stays high until accepted; `out_data` and the flags are stable while `out_valid`=1.

## Structure
- Package `parity_pkg`: state enum (IDLE, DATA, PARITY, STOP) and an `EVEN`/`ODD` sense constant.
- `bit_cnt` width is $clog2(WIDTH).
- One sub-module: `parity_acc`, a running-XOR accumulator with synchronous clear, enable, and async reset. It is the bit-serial parity engine, reused by the transmit side.
- Everything else (FSM, shift register, output register) lives in `parity_rx`.

## Test plan
- WIDTH=8, even parity, `out_ready`=1. Send start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1. Expect `out_data`=0xA5, `parity_err`=0, `frame_err`=0, and `out_valid` high for 1 cycle, one cycle after the stop bit.
- Send 0x07 with parity bit 0 (correct is 1). Expect `out_data`=0x07, `parity_err`=1. Repeat with ODD=1 and parity 0: expect `parity_err`=0.
- Send 0x3C with good parity and stop bit 0. Expect `out_data`=0x3C, `frame_err`=1, `parity_err`=0. A following good frame 0x55 is received cleanly.
- `out_ready`=0. Send 0x11 then 0x22. Expect `out_data` to stay 0x11 and `overrun`=1 after the second stop bit. Raise `out_ready` for one cycle: `out_valid`=0 and `overrun`=0.
- `out_valid`=1 with 0x11 held. Assert `out_ready` on exactly the edge the 0x22 stop bit is sampled. Expect `out_data`=0x22, `out_valid`=1, `overrun`=0.
- Random `in_valid` gaps of 0-5 cycles within frame 0x81 must not change the result. Assert `reset` mid-DATA: outputs go to 0 immediately, and the next full frame 0x5A is received correctly.
